serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Sequencer for a single 1-bit full-subtractor cell: difference x^y^b, borrow (~x&y)|(~(x^y)&b).
- Reuses that one cell over WIDTH clock cycles to compute an N-bit difference a - b - bin.
- The cell is LSB-first, with a registered borrow carried between bits.
- Sits between a requester with a start/done handshake and the cell, and owns operand shifting, borrow storage, bit counting and result capture.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  registered difference (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Operand shift registers, borrow flop and counter all cleared.
  - Reset has priority over every other event, including mid-SHIFT and in DONE.
  - An in-flight operation is abandoned with no done pulse; diff/bout return to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: load sa<=a, sb<=b, brw<=bin, cnt<=0, sres<=0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, once per cycle:
  - Feed x=sa[0], y=sb[0], brw into the cell.
  - sres <= {d, sres[WIDTH-1:1]}; sa/sb shift right by one; brw <= cell borrow; cnt <= cnt+1.
  - When cnt==WIDTH-1 on this cycle, go to DONE.
  - On that same edge: diff <= final sres value (including this bit) and bout <= final borrow.
- DONE:
  - done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency:
  - start sampled at edge E0 gives done=1 during the cycle after edge E0+WIDTH.
  - Start-to-done is WIDTH+1 cycles.
  - The earliest next accepted start is the edge that leaves DONE+1, i.e. the first IDLE cycle. Throughput is one operation per WIDTH+2 cycles.
- diff/bout update only on the SHIFT->DONE edge. They hold their value through IDLE and through the whole next operation until its own completion, and never show partial results.
- start while busy=1 (SHIFT or DONE) is ignored: no reload and no effect on the current operation. a/b/bin may change freely while busy.
- start held high continuously: a new operation is accepted each time IDLE is reached.
- WIDTH=1: exactly one SHIFT cycle; behaviour equals a single full subtractor with registered outputs.
- Arithmetic is unsigned modulo 2^WIDTH. bout equals bit WIDTH of the (WIDTH+1)-bit value {1'b0,a} - {1'b0,b} - bin, taken as the borrow.
- No X on any output after the first reset edge.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0, start pulse → busy high for 9 cycles; done pulses 9 cycles after start edge; diff=0x02, bout=0.
2. a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 → diff=0xFE, bout=0.
3. Mid-operation start: start a=0x10, b=0x01; assert start with a=0x00, b=0x55 at cycles 3 and 8 → both ignored; diff=0x0F, bout=0; exactly one done pulse. Previous diff is held unchanged until done.
4. Reset mid-SHIFT: assert rst on cycle 4 of an operation → next cycle busy=0, done=0, diff=0x00, bout=0; no done pulse follows. A new start afterwards completes normally.
5. start held high for 30 cycles with fixed a=0x80, b=0x01 → done pulses every 10 cycles; each result is diff=0x7F, bout=0.
6. WIDTH=1 instance, exhaustive over 8 (x,y,bin) combinations → each returns done after 2 cycles and matches the full-subtractor truth table (e.g. x=1, y=0, bin=1 → diff=0, bout=0; x=0, y=1, bin=1 → diff=0, bout=1).

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor controller: drives one 1-bit full-subtractor cell
// LSB-first over WIDTH cycles, carrying the borrow in a flop between bits.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sres, sres_nxt;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_x, cell_y, cell_d, cell_bo;
  logic             last_bit;

  // The single full-subtractor cell, fed from the operand LSBs and the borrow flop.
  assign cell_x  = sa[0];
  assign cell_y  = sb[0];
  assign cell_d  = cell_x ^ cell_y ^ brw;
  assign cell_bo = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & brw);

  // New difference bit enters at the MSB; the cast form stays legal when WIDTH is 1.
  assign sres_nxt = WIDTH'({cell_d, sres} >> 1);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // diff/bout are written only on the final bit so partial results are never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sres <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            brw  <= bin;
            cnt  <= '0;
            sres <= '0;
          end
        end
        SHIFT: begin
          sres <= sres_nxt;
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          brw  <= cell_bo;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            diff <= sres_nxt;
            bout <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: an 8-bit instance driven from a vector
// table plus corner sequences, and a 1-bit instance checked exhaustively.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  typedef struct {
    logic x;
    logic y;
    logic bin;
    logic diff;
    logic bout;
  } vec1_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       busy, done, bout;
  logic [7:0] diff;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int passed = 0;
  int total  = 0;

  vec_t  vecs[8];
  vec1_t vecs1[8];

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  // Pulse start from a negedge in IDLE and wait (bounded) for done on the 8-bit unit.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v,
                               input logic tbin, output int lat, output int busy_n);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 40; busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic applyStimulusW1(input logic tx, input logic ty, input logic tbin,
                                 output int lat, output int busy_n);
    a1 = tx; b1 = ty; bin1 = tbin; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 40; busy_n = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy1) busy_n++;
      if (done1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, busy_n, n_done;
    logic held;
    logic [7:0] prev;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_diff", diff, 0);
    checkOutput("reset_bout", bout, 0);
    checkOutput("reset_busy_w1", busy1, 0);
    checkOutput("reset_done_w1", done1, 0);
    checkOutput("reset_diff_w1", diff1, 0);
    checkOutput("reset_bout_w1", bout1, 0);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_n);
      checkOutput($sformatf("vec%0d_latency", i), lat, 9);
      checkOutput($sformatf("vec%0d_busy_cycles", i), busy_n, 9);
      checkOutput($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
      checkOutput($sformatf("vec%0d_bout", i), bout, vecs[i].bout);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
      checkOutput($sformatf("vec%0d_idle", i), busy, 0);
    end

    $display("[TB] start while busy is ignored");
    prev = vecs[7].diff;
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    held = 1'b1;
    lat = 40;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (diff !== prev) held = 1'b0;
      if (k == 3 || k == 8) begin
        start = 1'b1; a = 8'h00; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("busy_start_latency", lat, 9);
    checkOutput("busy_start_diff", diff, 8'h0F);
    checkOutput("busy_start_bout", bout, 0);
    checkOutput("busy_start_prev_held", held, 1);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checkOutput("busy_start_extra_done", n_done, 0);

    $display("[TB] reset mid-shift");
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_diff", diff, 0);
    checkOutput("midrst_bout", bout, 0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checkOutput("midrst_no_done", n_done, 0);
    checkOutput("midrst_diff_hold", diff, 0);
    applyStimulus(8'h05, 8'h03, 1'b0, lat, busy_n);
    checkOutput("postrst_latency", lat, 9);
    checkOutput("postrst_diff", diff, 8'h02);
    checkOutput("postrst_bout", bout, 0);
    @(negedge clk);

    $display("[TB] start held high");
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        checkOutput($sformatf("held_phase%0d", n_done), k % 10, 9);
        checkOutput($sformatf("held_diff%0d", n_done), diff, 8'h7F);
        checkOutput($sformatf("held_bout%0d", n_done), bout, 0);
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", n_done, 3);
    @(negedge clk);
    checkOutput("held_idle_after", busy, 0);

    $display("[TB] WIDTH=1 exhaustive");
    for (int i = 0; i < 8; i++) begin
      applyStimulusW1(vecs1[i].x, vecs1[i].y, vecs1[i].bin, lat, busy_n);
      checkOutput($sformatf("w1_%0d_latency", i), lat, 2);
      checkOutput($sformatf("w1_%0d_busy_cycles", i), busy_n, 2);
      checkOutput($sformatf("w1_%0d_diff", i), diff1, vecs1[i].diff);
      checkOutput($sformatf("w1_%0d_bout", i), bout1, vecs1[i].bout);
      @(negedge clk);
      checkOutput($sformatf("w1_%0d_done_pulse", i), done1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
